// File: rtl/gshare_pht_pkg.sv
// Shared types for the gshare pattern-history table: 2-bit counter encoding
// and the clear/ready control states.
package gshare_pht_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT = 2'd0;
   localparam ctr_t CTR_WNT = 2'd1;
   localparam ctr_t CTR_WT  = 2'd2;
   localparam ctr_t CTR_ST  = 2'd3;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

endpackage

// File: rtl/gshare_pht_ctr_update.sv
// Next value of a 2-bit saturating direction counter after a resolved branch.
module pht_ctr_update
   import gshare_pht_pkg::*;
(
   input  logic [1:0] counter,
   input  logic       taken,
   output logic [1:0] next_counter
);

   always_comb begin
      next_counter = counter;
      if (taken) begin
         if (counter != CTR_ST) next_counter = counter + 2'd1;
      end else begin
         if (counter != CTR_SNT) next_counter = counter - 2'd1;
      end
   end

endmodule

// File: rtl/gshare_pht.sv
// Gshare direction predictor table: pc/history-hashed 2-bit counters, swept to
// weak not-taken after reset, one-cycle prediction and same-edge update.
module gshare_pht
   import gshare_pht_pkg::*;
#(
   parameter int LG_PHT = 10,
   parameter int W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [W-1:0]      ghist,
   input  logic [63:0]       pc,
   input  logic              pred_req,
   output logic              pred_valid,
   output logic              pred_taken,
   output logic [LG_PHT-1:0] pred_idx,
   input  logic              upd_valid,
   input  logic [LG_PHT-1:0] upd_idx,
   input  logic              upd_taken,
   output logic              ready
);

   localparam int ENTRIES = 1 << LG_PHT;

   state_t            state;
   state_t            state_next;
   logic [LG_PHT-1:0] sweep_ptr;

   ctr_t              pht [ENTRIES];

   logic [LG_PHT-1:0] rd_idx;
   ctr_t              rd_ctr;
   ctr_t              upd_ctr;
   ctr_t              upd_next;
   logic              pred_fire;

   logic              wr_en;
   logic [LG_PHT-1:0] wr_idx;
   ctr_t              wr_data;

   logic              vld_p1;
   logic              taken_p1;
   logic [LG_PHT-1:0] idx_p1;

   logic              unused_bits;

   assign unused_bits = ^{pc, ghist};

   assign rd_idx    = pc[LG_PHT+1:2] ^ ghist[LG_PHT-1:0];
   assign rd_ctr    = pht[rd_idx];
   assign upd_ctr   = pht[upd_idx];
   assign ready     = (state == READY);
   assign pred_fire = pred_req && ready;

   pht_ctr_update u_ctr_update (
      .counter      (upd_ctr),
      .taken        (upd_taken),
      .next_counter (upd_next)
   );

   always_comb begin
      state_next = state;
      case (state)
         CLEAR:   if (sweep_ptr == {LG_PHT{1'b1}}) state_next = READY;
         READY:   state_next = READY;
         default: state_next = CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= CLEAR;
         sweep_ptr <= '0;
      end else begin
         state <= state_next;
         if (state == CLEAR) sweep_ptr <= sweep_ptr + 1'b1;
      end
   end

   // Single write port: the reset sweep owns it until the table is ready.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = upd_idx;
      wr_data = upd_next;
      if (state == CLEAR) begin
         wr_en   = 1'b1;
         wr_idx  = sweep_ptr;
         wr_data = CTR_WNT;
      end else if (upd_valid) begin
         wr_en = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) pht[wr_idx] <= wr_data;
   end

   // Stage p1: registered prediction; the read sees the pre-update counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1   <= 1'b0;
         taken_p1 <= 1'b0;
         idx_p1   <= '0;
      end else begin
         vld_p1 <= pred_fire;
         if (pred_fire) begin
            taken_p1 <= rd_ctr[1];
            idx_p1   <= rd_idx;
         end
      end
   end

   assign pred_valid = vld_p1;
   assign pred_taken = taken_p1;
   assign pred_idx   = idx_p1;

endmodule

// File: tb/tb_gshare_pht.sv
// Self-checking bench for gshare_pht with a 16-entry table: reference counter
// model, prediction scoreboard, vector table and directed corner sequences.
module tb_gshare_pht;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ghist = '0;
   logic [63:0] pc = '0;
   logic        pred_req = 1'b0;
   logic        pred_valid;
   logic        pred_taken;
   logic [3:0]  pred_idx;
   logic        upd_valid = 1'b0;
   logic [3:0]  upd_idx = '0;
   logic        upd_taken = 1'b0;
   logic        ready;

   gshare_pht #(.LG_PHT(4), .W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .ghist      (ghist),
      .pc         (pc),
      .pred_req   (pred_req),
      .pred_valid (pred_valid),
      .pred_taken (pred_taken),
      .pred_idx   (pred_idx),
      .upd_valid  (upd_valid),
      .upd_idx    (upd_idx),
      .upd_taken  (upd_taken),
      .ready      (ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       taken;
      logic [3:0] idx;
   } exp_t;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] ghist;
      logic [3:0]  idx;
      logic        taken;
   } vec_t;

   exp_t       q[$];
   exp_t       m_last;
   logic [1:0] model [16];
   logic       m_ready;
   logic       m_ready_n;
   logic [3:0] m_ptr;
   int         n_tests = 0;
   int         n_fail  = 0;
   vec_t       vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive at posedge+1, advance the model, check after the edge.
   task automatic step(input logic pr, input logic [63:0] p, input logic [31:0] g,
                       input logic uv, input logic [3:0] ui, input logic ut);
      logic [3:0] ix;
      exp_t       e;
      pred_req = pr; pc = p; ghist = g;
      upd_valid = uv; upd_idx = ui; upd_taken = ut;
      if (m_ready) begin
         if (pr) begin
            ix = p[5:2] ^ g[3:0];
            e.taken = model[ix][1];
            e.idx = ix;
            q.push_back(e);
         end
         if (uv) begin
            if (ut) begin
               if (model[ui] != 2'd3) model[ui] = model[ui] + 2'd1;
            end else begin
               if (model[ui] != 2'd0) model[ui] = model[ui] - 2'd1;
            end
         end
      end else begin
         model[m_ptr] = 2'd1;
         if (m_ptr == 4'hF) m_ready_n = 1'b1;
         m_ptr = m_ptr + 4'd1;
      end
      @(posedge clk);
      #1;
      m_ready = m_ready_n;
      chk("ready", ready, m_ready);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("pred_valid_hi", pred_valid, 1);
         chk("pred_taken", pred_taken, e.taken);
         chk("pred_idx", pred_idx, e.idx);
         m_last = e;
      end else begin
         chk("pred_valid_lo", pred_valid, 0);
         chk("hold_taken", pred_taken, m_last.taken);
         chk("hold_idx", pred_idx, m_last.idx);
      end
      pred_req = 1'b0;
      upd_valid = 1'b0;
   endtask

   task automatic predict(input logic [3:0] i);
      step(1'b1, {58'd0, i, 2'b00}, 32'd0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic upd(input logic [3:0] i, input logic t);
      step(1'b0, 64'd0, 32'd0, 1'b1, i, t);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      pred_req = 1'b0;
      upd_valid = 1'b0;
      #3;
      chk("rst_ready", ready, 0);
      chk("rst_pred_valid", pred_valid, 0);
      chk("rst_pred_taken", pred_taken, 0);
      chk("rst_pred_idx", pred_idx, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      m_ready = 1'b0;
      m_ready_n = 1'b0;
      m_ptr = 4'd0;
      q.delete();
      m_last = '0;
   endtask

   initial begin
      vecs[0] = '{64'h28, 32'h5, 4'hF, 1'b0};
      vecs[1] = '{64'h0, 32'h0, 4'h0, 1'b0};
      vecs[2] = '{64'h3C, 32'hFFFF_FFF0, 4'hF, 1'b0};
      vecs[3] = '{64'hFFFF_FFFF_FFFF_FFC4, 32'h3, 4'h2, 1'b0};
      vecs[4] = '{64'h14, 32'h5, 4'h0, 1'b0};
      vecs[5] = '{64'h1000_0020, 32'h1, 4'h9, 1'b0};

      for (int i = 0; i < 16; i++) model[i] = 2'd0;
      #2;
      do_reset();

      // Sweep with requests and updates held high; all must be ignored.
      for (int i = 0; i < 16; i++)
         step(1'b1, {$urandom, $urandom}, $urandom, 1'b1, 4'(i), 1'b1);
      chk("ready_after_sweep", ready, 1);

      for (int i = 0; i < 16; i++) begin
         predict(4'(i));
         chk("init_taken", pred_taken, 0);
         upd(4'(i), 1'b1);
         predict(4'(i));
         chk("init_was_weak", pred_taken, 1);
         upd(4'(i), 1'b0);
      end

      for (int i = 0; i < 6; i++) begin
         step(1'b1, vecs[i].pc, vecs[i].ghist, 1'b0, 4'd0, 1'b0);
         chk("vec_idx", pred_idx, vecs[i].idx);
         chk("vec_taken", pred_taken, vecs[i].taken);
         step(1'b0, 64'd0, 32'd0, 1'b0, 4'd0, 1'b0);
         chk("vec_one_shot", pred_valid, 0);
      end

      // Saturation at both ends on entry 3.
      for (int i = 0; i < 3; i++) upd(4'd3, 1'b1);
      predict(4'd3);
      chk("sat_hi_taken", pred_taken, 1);
      upd(4'd3, 1'b1);
      upd(4'd3, 1'b0);
      predict(4'd3);
      chk("sat_hi_held", pred_taken, 1);
      for (int i = 0; i < 4; i++) upd(4'd3, 1'b0);
      upd(4'd3, 1'b0);
      predict(4'd3);
      chk("sat_lo_held", pred_taken, 0);
      upd(4'd3, 1'b1);
      predict(4'd3);
      chk("sat_lo_plus1", pred_taken, 0);
      upd(4'd3, 1'b1);
      predict(4'd3);
      chk("sat_lo_plus2", pred_taken, 1);

      // Same-cycle prediction and taken update on entry 2 (counter 1).
      step(1'b1, 64'h8, 32'd0, 1'b1, 4'd2, 1'b1);
      chk("collide_old", pred_taken, 0);
      predict(4'd2);
      chk("collide_new", pred_taken, 1);

      for (int i = 0; i < 200; i++)
         step(1'($urandom), {$urandom, $urandom}, $urandom, 1'($urandom),
              4'($urandom), 1'($urandom));

      // Reset mid-sweep after training entry 5 to strong taken.
      upd(4'd5, 1'b1);
      upd(4'd5, 1'b1);
      upd(4'd5, 1'b1);
      predict(4'd5);
      chk("pre_reset_taken", pred_taken, 1);
      do_reset();
      for (int i = 0; i < 7; i++) step(1'b0, 64'd0, 32'd0, 1'b0, 4'd0, 1'b0);
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 64'h14, 32'h0, 1'b1, 4'd5, 1'b1);
      chk("ready_16_after", ready, 1);
      predict(4'd5);
      chk("update_lost", pred_taken, 0);
      upd(4'd5, 1'b1);
      predict(4'd5);
      chk("resweep_weak", pred_taken, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
